// File: rtl/ocm_arb_pkg.sv
// Shared types for the two-port on-chip-memory arbiter.
// Holds the ownership state encoding and the requester index type.
package ocm_arb_pkg;

  // Ownership state: nobody, port 0 or port 1 currently holds the RAM.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  // Index of a requester (0 or 1).
  typedef logic port_idx_t;

endpackage

// File: rtl/ocm_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single-port on-chip RAM with
// one-cycle read latency. The current owner keeps the RAM for up to
// BURST_MAX consecutive accesses while the other port waits, then hands over.
// Optional build macro OCM_ARB_ROUND_ROBIN_EN: ties seen from IDLE alternate
// between the ports instead of always going to port 0.
module ocm_arbiter
  import ocm_arb_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // requester 0
  input  logic [ADDR_W-1:0]     s0_address,
  input  logic                  s0_read,
  input  logic                  s0_write,
  input  logic [DATA_W-1:0]     s0_writedata,
  input  logic [DATA_W/8-1:0]   s0_byteenable,
  output logic                  s0_waitrequest,
  output logic [DATA_W-1:0]     s0_readdata,
  output logic                  s0_readdatavalid,
  // requester 1
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W-1:0]     s1_writedata,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  output logic                  s1_waitrequest,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  // RAM side
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int                CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_pend_q, rd_pend_d;
  port_idx_t        rd_tag_q, rd_tag_d;

  logic [1:0]       req;
  logic             sel_valid;
  port_idx_t        sel_port;
  port_idx_t        tie_port;
  port_idx_t        owner;
  port_idx_t        other;
  logic             sel_write;
  logic             sel_read;

`ifdef OCM_ARB_ROUND_ROBIN_EN
  port_idx_t        last_q, last_d;
`endif

  function automatic state_e own_state(input port_idx_t p);
    return p ? OWN1 : OWN0;
  endfunction

  assign req = {s1_read | s1_write, s0_read | s0_write};

  // Tie-break choice used when both ports request from IDLE.
  always_comb begin
`ifdef OCM_ARB_ROUND_ROBIN_EN
    tie_port = ~last_q;
`else
    tie_port = 1'b0;
`endif
  end

  // Selection and next-state: burst-limited ownership with handover.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_valid = 1'b0;
    sel_port  = 1'b0;
    owner     = (state_q == OWN1);
    other     = ~owner;
`ifdef OCM_ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req[0] && req[1]) begin
          sel_valid = 1'b1;
          sel_port  = tie_port;
`ifdef OCM_ARB_ROUND_ROBIN_EN
          last_d    = tie_port;
`endif
        end else if (req[0]) begin
          sel_valid = 1'b1;
          sel_port  = 1'b0;
        end else if (req[1]) begin
          sel_valid = 1'b1;
          sel_port  = 1'b1;
        end
        if (sel_valid) begin
          state_d = own_state(sel_port);
          cnt_d   = CNT_ONE;
        end
      end
      OWN0, OWN1: begin
        if (req[owner] && ((cnt_q < CNT_MAX) || !req[other])) begin
          // owner keeps the RAM; counter saturates at the burst limit
          sel_valid = 1'b1;
          sel_port  = owner;
          cnt_d     = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        end else if (req[other]) begin
          // burst exhausted or owner went idle: hand over
          sel_valid = 1'b1;
          sel_port  = other;
          state_d   = own_state(other);
          cnt_d     = CNT_ONE;
`ifdef OCM_ARB_ROUND_ROBIN_EN
          last_d    = other;
`endif
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // RAM command mux and read-tag capture for the selected port.
  always_comb begin
    sel_write      = sel_port ? s1_write : s0_write;
    sel_read       = sel_port ? s1_read : s0_read;
    mem_address    = sel_port ? s1_address : s0_address;
    mem_writedata  = sel_port ? s1_writedata : s0_writedata;
    mem_byteenable = sel_port ? s1_byteenable : s0_byteenable;
    mem_chipselect = sel_valid;
    mem_write      = sel_valid & sel_write;
    // read+write together is a write, so it never expects a response
    rd_pend_d      = sel_valid & sel_read & ~sel_write;
    rd_tag_d       = sel_port;
  end

  assign s0_waitrequest   = req[0] & ~(sel_valid & ~sel_port);
  assign s1_waitrequest   = req[1] & ~(sel_valid & sel_port);
  assign s0_readdata      = mem_readdata;
  assign s1_readdata      = mem_readdata;
  assign s0_readdatavalid = rd_pend_q & ~rd_tag_q;
  assign s1_readdatavalid = rd_pend_q & rd_tag_q;

  // State, burst counter and read-tag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

`ifdef OCM_ARB_ROUND_ROBIN_EN
  // Last tie/handover winner; reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: tb/tb_ocm_arbiter.sv
// Directed self-checking bench for ocm_arbiter with a behavioural
// one-cycle-latency RAM. Honours OCM_ARB_ROUND_ROBIN_EN for tie expectations.
module tb_ocm_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [14:0]  s0_address, s1_address;
  logic         s0_read, s0_write, s1_read, s1_write;
  logic [31:0]  s0_writedata, s1_writedata;
  logic [3:0]   s0_byteenable, s1_byteenable;
  logic         s0_waitrequest, s1_waitrequest;
  logic [31:0]  s0_readdata, s1_readdata;
  logic         s0_readdatavalid, s1_readdatavalid;
  logic [14:0]  mem_address;
  logic         mem_chipselect, mem_write;
  logic [31:0]  mem_writedata;
  logic [3:0]   mem_byteenable;
  logic [31:0]  mem_readdata = '0;

  logic [31:0]  ram [0:32767];

  int checks = 0;
  int errors = 0;
  int tie_exp [3];
  int burst_w [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  always #5 clk = ~clk;

  ocm_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata)
  );

  // RAM model: byte-masked write, registered read.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      mem_readdata <= ram[mem_address];
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
        end
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    s0_read = 1'b0; s0_write = 1'b0; s0_address = '0; s0_writedata = '0; s0_byteenable = 4'hF;
    s1_read = 1'b0; s1_write = 1'b0; s1_address = '0; s1_writedata = '0; s1_byteenable = 4'hF;
  endtask

  initial begin
`ifdef OCM_ARB_ROUND_ROBIN_EN
    tie_exp = '{0, 1, 0};
`else
    tie_exp = '{0, 0, 0};
`endif
    ram[15'h0010] = 32'h1234_5678;
    ram[15'h0020] = 32'hCAFE_F00D;
    ram[15'h0040] = 32'h5555_5555;
    ram[15'h7FFF] = 32'hA5A5_C3C3;
    reset_n = 1'b0;
    idle_inputs();

    // reset state
    #2;
    $display("txn reset");
    chk1("rst_rdv0", s0_readdatavalid, 1'b0);
    chk1("rst_rdv1", s1_readdatavalid, 1'b0);
    chk1("rst_wr0", s0_waitrequest, 1'b0);
    chk1("rst_cs", mem_chipselect, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // single read on port 0
    @(negedge clk);
    $display("txn s0 read 0x0010");
    s0_read = 1'b1; s0_address = 15'h0010;
    #1;
    chk1("rd0_wr0", s0_waitrequest, 1'b0);
    chk1("rd0_cs", mem_chipselect, 1'b1);
    chk32("rd0_addr", 32'(mem_address), 32'h0010);
    chk1("rd0_mwr", mem_write, 1'b0);
    @(negedge clk);
    idle_inputs();
    chk1("rd0_rdv0", s0_readdatavalid, 1'b1);
    chk32("rd0_data", s0_readdata, 32'h1234_5678);
    chk1("rd0_rdv1", s1_readdatavalid, 1'b0);

    // three ties from IDLE, one idle cycle between
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      $display("txn tie %0d", t);
      s0_read = 1'b1; s0_address = 15'h0010;
      s1_read = 1'b1; s1_address = 15'h0020;
      #1;
      chk1("tie_wr0", s0_waitrequest, tie_exp[t] != 0);
      chk1("tie_wr1", s1_waitrequest, tie_exp[t] != 1);
      @(negedge clk);
      idle_inputs();
      chk1("tie_rdv0", s0_readdatavalid, tie_exp[t] == 0);
      chk1("tie_rdv1", s1_readdatavalid, tie_exp[t] == 1);
    end

    // reset asserted the cycle after an accepted read
    @(negedge clk);
    $display("txn s0 read then reset");
    s0_read = 1'b1; s0_address = 15'h0010;
    #1;
    chk1("rstrd_wr0", s0_waitrequest, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk1("rstrd_rdv0", s0_readdatavalid, 1'b0);
    chk1("rstrd_rdv1", s1_readdatavalid, 1'b0);
    reset_n = 1'b1;

    // both ports read continuously: first tie after reset goes to port 0
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      $display("txn burst cycle %0d expect port %0d", k, burst_w[k]);
      if (k > 0) begin
        chk1("burst_rdv0", s0_readdatavalid, burst_w[k-1] == 0);
        chk1("burst_rdv1", s1_readdatavalid, burst_w[k-1] == 1);
        chk32("burst_data", s0_readdata, (burst_w[k-1] == 1) ? 32'hCAFE_F00D : 32'h1234_5678);
      end
      s0_read = 1'b1; s0_address = 15'h0010;
      s1_read = 1'b1; s1_address = 15'h0020;
      #1;
      chk1("burst_wr0", s0_waitrequest, burst_w[k] == 1);
      chk1("burst_wr1", s1_waitrequest, burst_w[k] == 0);
      chk32("burst_addr", 32'(mem_address), (burst_w[k] == 1) ? 32'h0020 : 32'h0010);
    end
    @(negedge clk);
    idle_inputs();
    chk1("burst_end_rdv0", s0_readdatavalid, 1'b1);
    chk1("burst_end_rdv1", s1_readdatavalid, 1'b0);

    // port 1 partial write, port 0 reads same word next cycle
    @(negedge clk);
    $display("txn s1 write 0x7FFF");
    s1_write = 1'b1; s1_address = 15'h7FFF; s1_writedata = 32'hDEAD_BEEF; s1_byteenable = 4'h3;
    #1;
    chk1("wr1_wr1", s1_waitrequest, 1'b0);
    chk1("wr1_mwr", mem_write, 1'b1);
    chk32("wr1_addr", 32'(mem_address), 32'h7FFF);
    chk32("wr1_be", 32'(mem_byteenable), 32'h3);
    chk32("wr1_data", mem_writedata, 32'hDEAD_BEEF);
    @(negedge clk);
    $display("txn s0 read 0x7FFF");
    idle_inputs();
    s0_read = 1'b1; s0_address = 15'h7FFF;
    #1;
    chk1("wrrd_wr0", s0_waitrequest, 1'b0);
    chk1("wrrd_mwr", mem_write, 1'b0);
    chk1("wrrd_rdv1", s1_readdatavalid, 1'b0);
    @(negedge clk);
    idle_inputs();
    chk1("wrrd_rdv0", s0_readdatavalid, 1'b1);
    chk32("wrrd_data", s0_readdata, 32'hA5A5_BEEF);
    chk1("wrrd_rdv1b", s1_readdatavalid, 1'b0);

    // read and write together behave as a write
    @(negedge clk);
    $display("txn s0 read+write 0x0040");
    s0_read = 1'b1; s0_write = 1'b1; s0_address = 15'h0040; s0_writedata = 32'h1111_1111;
    #1;
    chk1("rw_mwr", mem_write, 1'b1);
    chk1("rw_cs", mem_chipselect, 1'b1);
    @(negedge clk);
    $display("txn s0 read 0x0040");
    idle_inputs();
    chk1("rw_rdv0", s0_readdatavalid, 1'b0);
    chk1("rw_rdv1", s1_readdatavalid, 1'b0);
    s0_read = 1'b1; s0_address = 15'h0040;
    @(negedge clk);
    idle_inputs();
    chk1("rwrd_rdv0", s0_readdatavalid, 1'b1);
    chk32("rwrd_data", s0_readdata, 32'h1111_1111);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ocm_arbiter.md
OCM_ARBITER -- requirements
Module: ocm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, word address width of the shared on-chip RAM.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter BURST_MAX, default 4, maximum consecutive accepted accesses per grant holder when the other port waits.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have, per requester i in {0,1}: sN_address in ADDR_W, sN_read in 1, sN_write in 1, sN_writedata in DATA_W, sN_byteenable in DATA_W/8 (Avalon-MM slave-side command).
REQ-007 SHALL have, per requester: sN_waitrequest out 1, sN_readdata out DATA_W, sN_readdatavalid out 1.
REQ-008 SHALL have memory side: mem_address out ADDR_W, mem_chipselect out 1, mem_write out 1, mem_writedata out DATA_W, mem_byteenable out DATA_W/8, mem_readdata in DATA_W (RAM read latency exactly 1 cycle).

Function
REQ-009 A command on port i SHALL be accepted in a cycle where (sN_read|sN_write) is high and sN_waitrequest is low; at most one acceptance per cycle across both ports.
REQ-010 sN_waitrequest SHALL be combinational: high when port requests and is not selected this cycle, low otherwise (including when idle).
REQ-011 Selection SHALL use state IDLE, OWN0, OWN1 plus burst counter cnt (0..BURST_MAX).
REQ-012 In OWNi with port i requesting and (cnt<BURST_MAX or other port idle): select i, cnt<=min(cnt+1,BURST_MAX).
REQ-013 In OWNi with port i requesting, cnt==BURST_MAX, other port requesting: select other, state<=OWN(other), cnt<=1.
REQ-014 In OWNi with port i idle: select other if requesting (state<=OWN(other), cnt<=1), else state<=IDLE, cnt<=0.
REQ-015 In IDLE: single requester wins; both requesting resolved per REQ-023; state<=OWN(winner), cnt<=1.
REQ-016 When a port is selected, mem_* SHALL mirror that port's address/writedata/byteenable combinationally, mem_chipselect=1, mem_write=sN_write; no selection: mem_chipselect=0, mem_write=0.
REQ-017 sN_read and sN_write both high SHALL be treated as write only.
REQ-018 Accepted read on port i at cycle N SHALL produce sN_readdatavalid=1 at cycle N+1 with sN_readdata=mem_readdata; tag register records owner; back-to-back reads give one valid per cycle, full throughput.
REQ-019 sN_readdata SHALL be mem_readdata routed to both ports; only readdatavalid qualifies it.
REQ-020 Writes SHALL produce no response; write-then-read same address on consecutive cycles SHALL return new data (RAM ordering, no reordering in arbiter).

Reset
REQ-021 On reset_n low, immediately: state=IDLE, cnt=0, both readdatavalid=0, read tag cleared, last-winner=1 (port 0 wins first tie); a read accepted the cycle before reset SHALL NOT produce readdatavalid.
REQ-022 Reset deassertion SHALL be synchronised externally; first acceptance possible in the first cycle after release.

Configuration
REQ-023 Macro OCM_ARB_ROUND_ROBIN_EN defined: IDLE tie goes to the port that did not win the previous tie/handover (last-winner register); undefined: IDLE tie always to port 0, last-winner register absent; REQ-012..014 burst limit identical in both builds.

Structure
REQ-024 Package ocm_arb_pkg SHALL hold state enum (IDLE, OWN0, OWN1) and port-index typedef; no other shared constants.
REQ-025 No sub-module; single flat module.

Verification
REQ-026 Port0 reads addr 0x0010 alone -> accepted cycle 0, s0_readdatavalid cycle 1 with RAM word, s1 untouched.
REQ-027 Both ports read continuously, BURST_MAX=4 -> acceptance pattern 0,0,0,0,1,1,1,1,0,... ; waitrequest high on waiting port only.
REQ-028 Both idle-ties from IDLE three times, OCM_ARB_ROUND_ROBIN_EN defined -> winners 0,1,0; undefined -> 0,0,0.
REQ-029 Port1 writes 0xDEADBEEF byteenable 0x3 to 0x7FFF, then port0 reads 0x7FFF next cycle -> low halfword 0xBEEF, upper unchanged, valid on s0 only.
REQ-030 reset_n asserted cycle after accepted read -> no readdatavalid; after release, state IDLE and first tie to port 0.
REQ-031 sN_read and sN_write both high -> mem_write=1, no readdatavalid.
